mem_stage_ctrl: RTL and testbench

//  MEM-stage data-access controller between the EX/MEM pipe register and the MEM/WB pipe register.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/mem_stage_ctrl_link_reg.sv | 60 ++++++
 rtl/mem_stage_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types; adds the MEM-stage controller state encoding.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        MC_IDLE   = 2'd0,
        MC_ACCESS = 2'd1,
        MC_DONE   = 2'd2
    } memctl_state_t;

endpackage

// File: rtl/mem_stage_ctrl_link_reg.sv
// LL/SC reservation register: set by LL hit, cleared by snoop, SC, or own store to the linked word.
// Snoop invalidate outranks a same-cycle LL so a racing writer always breaks the new link.
module link_reg
    import cpu_types_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LINK_LSB = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ccinv,
    input  logic [DATA_W-1:0] ccsnoopaddr,
    input  logic              ll_hit,
    input  logic              sc_hit,
    input  logic              sw_hit,
    input  logic [DATA_W-1:0] hit_addr,
    output logic              link_valid,
    output logic [DATA_W-1:0] link_addr
);

    logic              link_valid_q, link_valid_d;
    logic [DATA_W-1:0] link_addr_q,  link_addr_d;
    logic              snoop_link, snoop_new, sw_link;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    always_comb begin
        snoop_link = link_valid_q &&
                     (ccsnoopaddr[DATA_W-1:LINK_LSB] == link_addr_q[DATA_W-1:LINK_LSB]);
        snoop_new  = ll_hit &&
                     (ccsnoopaddr[DATA_W-1:LINK_LSB] == hit_addr[DATA_W-1:LINK_LSB]);
        sw_link    = link_valid_q &&
                     (hit_addr[DATA_W-1:LINK_LSB] == link_addr_q[DATA_W-1:LINK_LSB]);

        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (ccinv && (snoop_link || snoop_new)) begin
            link_valid_d = 1'b0;
        end else if (sc_hit) begin
            link_valid_d = 1'b0;
        end else if (ll_hit) begin
            link_valid_d = 1'b1;
            link_addr_d  = hit_addr;
        end else if (sw_hit && sw_link) begin
            link_valid_d = 1'b0;
        end
    end

    assign link_valid = link_valid_q;
    assign link_addr  = link_addr_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage dcache access controller: issues/holds requests until dhit, stalls upstream, owns LL/SC link.
// A hit in the issue cycle completes at once; DONE never re-issues while the pipe is held.
module mem_stage_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LINK_LSB = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              mem_valid,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic              ll_in,
    input  logic              sc_in,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] store_in,
    input  logic              advance,
    input  logic              flush,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dcache_load,
    input  logic              ccinv,
    input  logic [DATA_W-1:0] ccsnoopaddr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [DATA_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [DATA_W-1:0] mem_result,
    output logic              link_valid,
    output logic [DATA_W-1:0] link_addr
);

    localparam logic [DATA_W-1:0] SC_OK = DATA_W'(1);

    memctl_state_t     state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              link_match, sc_fail, need;
    logic              req, hit, ll_hit, sc_hit, sw_hit;

    always_comb begin
        link_match = link_valid &&
                     (link_addr[DATA_W-1:LINK_LSB] == addr_in[DATA_W-1:LINK_LSB]);
        sc_fail    = sc_in && dWEN_in && !link_match;
        need       = mem_valid && (dREN_in || dWEN_in) && !sc_fail;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= MC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MC_IDLE: begin
                if (req) state_d = dhit ? MC_DONE : MC_ACCESS;
            end
            MC_ACCESS: begin
                if (!mem_valid)  state_d = MC_IDLE;
                else if (dhit)   state_d = MC_DONE;
            end
            MC_DONE: begin
                if (flush || advance) state_d = MC_IDLE;
            end
            default: state_d = MC_IDLE;
        endcase
    end

    // Reset gates the request so an access in flight drops the same instant nRST falls.
    always_comb begin
        req = 1'b0;
        case (state_q)
            MC_IDLE:   req = need && !flush;
            MC_ACCESS: req = mem_valid;
            default:   req = 1'b0;
        endcase
        req = req && nRST;

        dmemREN   = req && dREN_in;
        dmemWEN   = req && dWEN_in && !dREN_in;
        dmemaddr  = req ? addr_in  : '0;
        dmemstore = req ? store_in : '0;
        mem_stall = req && !dhit;
        hit       = req && dhit;
        ll_hit    = hit && dREN_in && ll_in;
        sc_hit    = hit && dWEN_in && sc_in;
        sw_hit    = hit && dWEN_in && !sc_in && !dREN_in;
    end

    always_comb begin
        result_d = result_q;
        if (hit) begin
            result_d = sc_hit ? SC_OK : dcache_load;
        end else if (state_q != MC_ACCESS &&
                     (flush || (state_q == MC_IDLE && mem_valid && sc_fail))) begin
            result_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign mem_result = result_q;

    link_reg #(
        .DATA_W   (DATA_W),
        .LINK_LSB (LINK_LSB)
    ) u_link_reg (
        .CLK         (CLK),
        .nRST        (nRST),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .ll_hit      (ll_hit),
        .sc_hit      (sc_hit),
        .sw_hit      (sw_hit),
        .hit_addr    (addr_in),
        .link_valid  (link_valid),
        .link_addr   (link_addr)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed scenarios plus randomized traffic against a transaction-level reference of the MEM stage.
module tb_mem_stage_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        mem_valid, dREN_in, dWEN_in, ll_in, sc_in;
    logic [31:0] addr_in, store_in;
    logic        advance, flush, dhit;
    logic [31:0] dcache_load;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
    logic        dmemREN, dmemWEN, mem_stall, link_valid;
    logic [31:0] dmemaddr, dmemstore, mem_result, link_addr;

    mem_stage_ctrl dut (
        .CLK(CLK), .nRST(nRST), .mem_valid(mem_valid), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
        .ll_in(ll_in), .sc_in(sc_in), .addr_in(addr_in), .store_in(store_in),
        .advance(advance), .flush(flush), .dhit(dhit), .dcache_load(dcache_load),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
        .mem_result(mem_result), .link_valid(link_valid), .link_addr(link_addr)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int n_wen, n_stall, n_ren_stall;

    // Reference: an access is either waiting for the cache, finished awaiting advance, or neither.
    bit          m_busy, m_done, m_lv;
    logic [31:0] m_res, m_la;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

    task automatic model_clear();
        m_busy = 0; m_done = 0; m_lv = 0; m_res = '0; m_la = '0;
    endtask

    task automatic clear_inputs();
        mem_valid = 0; dREN_in = 0; dWEN_in = 0; ll_in = 0; sc_in = 0;
        addr_in = '0; store_in = '0; advance = 0; flush = 0; dhit = 0;
        dcache_load = '0; ccinv = 0; ccsnoopaddr = '0;
    endtask

    task automatic set_instr(input bit ren, input bit wen, input bit ll, input bit sc,
                             input logic [31:0] a, input logic [31:0] s);
        mem_valid = 1; dREN_in = ren; dWEN_in = wen; ll_in = ll; sc_in = sc;
        addr_in = a; store_in = s;
    endtask

    // One clock: check combinational outputs mid-cycle, then advance the reference on the edge.
    task automatic step();
        bit scf, want, req, hit, kill;
        @(negedge CLK);
        scf  = sc_in && dWEN_in && !(m_lv && same_word(m_la, addr_in));
        want = mem_valid && (dREN_in || dWEN_in) && !scf;
        if (m_busy)      req = mem_valid;
        else if (m_done) req = 0;
        else             req = want && !flush;
        hit = req && dhit;

        chk("ren",   dmemREN,   req && dREN_in);
        chk("wen",   dmemWEN,   req && dWEN_in && !dREN_in);
        chk("addr",  dmemaddr,  req ? addr_in : 32'h0);
        chk("store", dmemstore, req ? store_in : 32'h0);
        chk("stall", mem_stall, req && !dhit);
        chk("res",   mem_result, m_res);
        chk("lv",    link_valid, m_lv);
        chk("la",    link_addr,  m_la);
        if (dmemWEN) n_wen++;
        if (mem_stall) n_stall++;
        if (dmemREN && mem_stall) n_ren_stall++;

        @(posedge CLK);
        if (hit) m_res = (sc_in && dWEN_in) ? 32'h1 : dcache_load;
        else if (!m_busy && (flush || (!m_done && mem_valid && scf))) m_res = '0;

        kill = ccinv && ((m_lv && same_word(ccsnoopaddr, m_la)) ||
                         (hit && ll_in && dREN_in && same_word(ccsnoopaddr, addr_in)));
        if (kill) m_lv = 0;
        else if (hit && sc_in && dWEN_in) m_lv = 0;
        else if (hit && ll_in && dREN_in) begin m_lv = 1; m_la = addr_in; end
        else if (hit && dWEN_in && !sc_in && m_lv && same_word(addr_in, m_la)) m_lv = 0;

        if (hit) begin
            m_busy = 0; m_done = 1;
        end else if (m_busy) begin
            if (!mem_valid) m_busy = 0;
        end else if (m_done) begin
            if (flush || advance) m_done = 0;
        end else if (req) begin
            m_busy = 1;
        end
        #1;
    endtask

    task automatic run_access(input bit ren, input bit wen, input bit ll, input bit sc,
                              input logic [31:0] a, input logic [31:0] s, input int wt,
                              input logic [31:0] load);
        set_instr(ren, wen, ll, sc, a, s);
        advance = 0; dhit = 0; dcache_load = load;
        repeat (wt) step();
        dhit = 1; step();
        dhit = 0; advance = 1; step();
        advance = 0; mem_valid = 0; dREN_in = 0; dWEN_in = 0; ll_in = 0; sc_in = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_stall", mem_stall, 0);
        chk("rst_ren",   dmemREN, 0);
        chk("rst_wen",   dmemWEN, 0);
        chk("rst_res",   mem_result, 0);
        chk("rst_lv",    link_valid, 0);
        chk("rst_la",    link_addr, 0);
        nRST = 1;
    endtask

    logic [31:0] addrs [4];

    initial begin
        addrs = '{32'h100, 32'h104, 32'h200, 32'h204};
        do_reset();

        // LW with three wait cycles
        n_stall = 0; n_ren_stall = 0;
        run_access(1, 0, 0, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        chk("t1_stall_cycles", n_stall, 3);
        chk("t1_ren_stall",    n_ren_stall, 3);
        chk("t1_res",          mem_result, 32'hDEADBEEF);

        // LL then SC to the same word
        run_access(1, 0, 1, 0, 32'h200, 32'h0, 1, 32'h1234);
        chk("t2_link", link_valid, 1);
        n_wen = 0;
        run_access(0, 1, 0, 1, 32'h200, 32'h55, 0, 32'h0);
        chk("t2_wen_once", n_wen, 1);
        chk("t2_res",      mem_result, 1);
        chk("t2_link_off", link_valid, 0);

        // Snoop of a neighbouring word keeps the link
        run_access(1, 0, 1, 0, 32'h200, 32'h0, 0, 32'hABCD);
        ccinv = 1; ccsnoopaddr = 32'h204; step(); ccinv = 0;
        chk("t3_keep", link_valid, 1);
        run_access(0, 1, 0, 1, 32'h200, 32'h66, 1, 32'h0);
        chk("t3_sc_ok", mem_result, 1);
        // Snoop of the linked word breaks it; SC must fail without a request
        run_access(1, 0, 1, 0, 32'h200, 32'h0, 0, 32'h7777);
        ccinv = 1; ccsnoopaddr = 32'h200; step(); ccinv = 0;
        chk("t3_drop", link_valid, 0);
        set_instr(0, 1, 0, 1, 32'h200, 32'h77);
        n_stall = 0; n_wen = 0;
        step(); step();
        chk("t3_sc_fail_res", mem_result, 0);
        chk("t3_sc_no_wen",   n_wen, 0);
        chk("t3_sc_no_stall", n_stall, 0);
        mem_valid = 0;

        // LL hit racing an invalidate of the same word
        ccinv = 1; ccsnoopaddr = 32'h200;
        run_access(1, 0, 1, 0, 32'h200, 32'h0, 0, 32'h4242);
        ccinv = 0;
        chk("t4_race", link_valid, 0);
        set_instr(0, 1, 0, 1, 32'h200, 32'h1);
        step();
        chk("t4_sc_fail", mem_result, 0);
        mem_valid = 0;

        // SW completes once and holds in DONE while the pipe is stalled
        set_instr(0, 1, 0, 0, 32'h300, 32'hCAFE);
        dhit = 1; advance = 0; n_wen = 0;
        repeat (5) step();
        chk("t5_one_write", n_wen, 1);
        advance = 1; dhit = 0; step();
        advance = 0; mem_valid = 0; dWEN_in = 0;

        // Flush in ACCESS is ignored; async reset mid-access drops everything
        run_access(1, 0, 1, 0, 32'h100, 32'h0, 0, 32'h11);
        set_instr(1, 0, 0, 0, 32'h104, 32'h0);
        step(); step();
        flush = 1; step();
        #2 nRST = 0;
        #1;
        chk("t6_ren",   dmemREN, 0);
        chk("t6_stall", mem_stall, 0);
        chk("t6_link",  link_valid, 0);
        chk("t6_res",   mem_result, 0);
        model_clear();
        clear_inputs();
        @(posedge CLK); #1 nRST = 1;
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!m_busy && !m_done) begin
                case ($urandom_range(0, 5))
                    0: begin mem_valid = $urandom_range(0, 1); dREN_in = 0; dWEN_in = 0; ll_in = 0; sc_in = 0; end
                    1: set_instr(1, 0, 0, 0, addrs[$urandom_range(0, 3)], $urandom);
                    2: set_instr(0, 1, 0, 0, addrs[$urandom_range(0, 3)], $urandom);
                    3: set_instr(1, 0, 1, 0, addrs[$urandom_range(0, 3)], $urandom);
                    default: set_instr(0, 1, 0, 1, addrs[$urandom_range(0, 3)], $urandom);
                endcase
            end
            advance     = ($urandom_range(0, 2) == 0);
            dhit        = ($urandom_range(0, 2) == 0);
            dcache_load = $urandom;
            ccinv       = ($urandom_range(0, 7) == 0);
            ccsnoopaddr = addrs[$urandom_range(0, 3)];
            flush       = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
